// File: rtl/time_pkg.sv
// Shared constants for the stopwatch time-digit counters: direction and
// terminal-mode encodings plus the per-stage moduli.
package time_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;
    localparam int unsigned HR_MOD  = 24;

endpackage : time_pkg

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter stage with clear/load, wrap or saturate mode,
// a same-cycle carry/borrow for cascading, and a lap-capture register.
module mod_n_counter
    import time_pkg::*;
#(
    parameter int unsigned MODULUS   = 60,
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic             wrap_en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             lap,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             done,
    output logic [WIDTH-1:0] lap_val,
    output logic             lap_valid
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lap_val_q, lap_val_d;
    logic             lap_valid_q, lap_valid_d;
    logic             at_term;
    logic             load_oor;

    assign at_term  = (dir == DIR_DOWN) ? (count_q == '0) : (count_q == MAX_VAL);
    assign load_oor = (32'(load_val) >= MODULUS);

    // Carry must be visible in the same cycle so the next stage steps on the
    // very edge this one wraps; anything that overrides the step kills it.
    assign ovf = enable & at_term & (wrap_en == MODE_WRAP) & ~done_q
               & ~clear & ~load & ~rst;

    always_comb begin
        count_d     = count_q;
        done_d      = done_q;
        lap_val_d   = lap ? count_q : lap_val_q;
        lap_valid_d = lap;

        if (clear) begin
            count_d = RST_VAL;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_oor ? MAX_VAL : load_val;
            done_d  = 1'b0;
        end else if (enable && !done_q) begin
            if (!at_term) begin
                count_d = (dir == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
            end else if (wrap_en == MODE_WRAP) begin
                count_d = (dir == DIR_DOWN) ? MAX_VAL : '0;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= RST_VAL;
            done_q      <= 1'b0;
            lap_val_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            done_q      <= done_d;
            lap_val_q   <= lap_val_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign count     = count_q;
    assign done      = done_q;
    assign lap_val   = lap_val_q;
    assign lap_valid = lap_valid_q;

endmodule : mod_n_counter

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: a seconds stage cascaded into a minutes stage,
// checked every cycle against an arithmetic model of both stages.
module tb_mod_n_counter;
    import time_pkg::*;

    localparam int W = 6;

    logic         clk;
    logic         rst;
    logic         en;
    logic         dir;
    logic         wrap;
    logic         clr;
    logic         ld;
    logic [W-1:0] ld_val;
    logic         lap;
    logic         min_clr;
    logic         min_ld;
    logic [W-1:0] min_ld_val;
    logic         min_lap;

    logic [W-1:0] sec_count, sec_lap_val, min_count, min_lap_val;
    logic         sec_ovf, sec_done, sec_lap_valid;
    logic         min_ovf, min_done, min_lap_valid;

    mod_n_counter #(.MODULUS(SEC_MOD), .WIDTH(W), .RESET_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .enable(en), .dir(dir), .wrap_en(wrap),
        .clear(clr), .load(ld), .load_val(ld_val), .lap(lap),
        .count(sec_count), .ovf(sec_ovf), .done(sec_done),
        .lap_val(sec_lap_val), .lap_valid(sec_lap_valid)
    );

    mod_n_counter #(.MODULUS(MIN_MOD), .WIDTH(W), .RESET_VAL(0)) u_min (
        .clk(clk), .rst(rst), .enable(sec_ovf), .dir(dir), .wrap_en(wrap),
        .clear(min_clr), .load(min_ld), .load_val(min_ld_val), .lap(min_lap),
        .count(min_count), .ovf(min_ovf), .done(min_done),
        .lap_val(min_lap_val), .lap_valid(min_lap_valid)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_hits = 0;

    // Reference model: index 0 = seconds, 1 = minutes
    int  m_cnt[2];
    bit  m_done[2];
    int  m_lapv[2];
    bit  m_lapvalid[2];
    int  m_mod[2];
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int term_of(int s);
        return (dir == DIR_DOWN) ? 0 : m_mod[s] - 1;
    endfunction

    function automatic logic exp_ovf(int s, logic en_i);
        logic c, l;
        c = (s == 0) ? clr : min_clr;
        l = (s == 0) ? ld  : min_ld;
        return !rst && en_i && wrap && !m_done[s] && !c && !l && (m_cnt[s] == term_of(s));
    endfunction

    task automatic model_update(input int s, input logic en_i, input logic c,
                                input logic l, input int lv, input logic lp);
        int stepv;
        if (rst) begin
            m_cnt[s] = 0; m_done[s] = 0; m_lapv[s] = 0; m_lapvalid[s] = 0;
            if (s == 0) exp_q.delete();
            return;
        end
        m_lapvalid[s] = lp;
        if (lp) begin
            m_lapv[s] = m_cnt[s];
            if (s == 0) exp_q.push_back(W'(m_cnt[s]));
        end
        stepv = (dir == DIR_DOWN) ? m_mod[s] - 1 : 1;
        if (c) begin
            m_cnt[s] = 0; m_done[s] = 0;
        end else if (l) begin
            m_cnt[s] = (lv >= m_mod[s]) ? m_mod[s] - 1 : lv;
            m_done[s] = 0;
        end else if (en_i && !m_done[s]) begin
            if (!wrap && m_cnt[s] == term_of(s)) m_done[s] = 1;
            else m_cnt[s] = (m_cnt[s] + stepv) % m_mod[s];
        end
    endtask

    // One clock: check combinational ovf, clock, update model, check registers.
    task automatic step();
        logic e_sec, e_min;
        logic [W-1:0] popped;
        #1;
        e_sec = exp_ovf(0, en);
        e_min = exp_ovf(1, e_sec);
        check("sec_ovf", 32'(sec_ovf), 32'(e_sec));
        check("min_ovf", 32'(min_ovf), 32'(e_min));
        if (sec_ovf === 1'b1) ovf_hits++;
        @(posedge clk);
        model_update(0, en, clr, ld, int'(ld_val), lap);
        model_update(1, e_sec, min_clr, min_ld, int'(min_ld_val), min_lap);
        #1;
        check("sec_count", 32'(sec_count), 32'(m_cnt[0]));
        check("sec_done", 32'(sec_done), 32'(m_done[0]));
        check("sec_lap_valid", 32'(sec_lap_valid), 32'(m_lapvalid[0]));
        check("sec_lap_val", 32'(sec_lap_val), 32'(m_lapv[0]));
        check("min_count", 32'(min_count), 32'(m_cnt[1]));
        check("min_done", 32'(min_done), 32'(m_done[1]));
        if (m_lapvalid[0]) begin
            if (exp_q.size() == 0) begin
                check("lap_sb_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                popped = exp_q.pop_front();
                check("lap_sb", 32'(sec_lap_val), 32'(popped));
            end
        end
    endtask

    task automatic idle_inputs();
        en = 0; clr = 0; ld = 0; ld_val = '0; lap = 0;
        min_clr = 0; min_ld = 0; min_ld_val = '0; min_lap = 0;
    endtask

    task automatic do_load(input int v);
        ld = 1; ld_val = W'(v); en = 0;
        step();
        ld = 0;
    endtask

    initial begin
        int min_max;
        logic [W-1:0] hold_sec, hold_min;
        m_mod[0] = SEC_MOD; m_mod[1] = MIN_MOD;
        m_cnt = '{0, 0}; m_done = '{0, 0}; m_lapv = '{0, 0}; m_lapvalid = '{0, 0};
        idle_inputs();
        rst = 1; dir = DIR_DOWN; wrap = MODE_WRAP; en = 1;

        // Reset: ovf must stay low while rst is high even at a terminal value
        step(); step();
        check("rst_count", 32'(sec_count), 32'd0);
        check("rst_lap_val", 32'(sec_lap_val), 32'd0);

        // Up wrap through a full period
        rst = 0; dir = DIR_UP; en = 1; ovf_hits = 0;
        for (int i = 0; i < 61; i++) step();
        check("upwrap_final", 32'(sec_count), 32'd1);
        check("upwrap_ovf_hits", 32'(ovf_hits), 32'd1);

        // Down saturate from 3
        do_load(3);
        en = 1; dir = DIR_DOWN; wrap = MODE_SAT; ovf_hits = 0;
        for (int i = 0; i < 7; i++) step();
        check("sat_count", 32'(sec_count), 32'd0);
        check("sat_done", 32'(sec_done), 32'd1);
        check("sat_ovf_hits", 32'(ovf_hits), 32'd0);
        dir = DIR_UP; step();
        check("sat_dir_keep_done", 32'(sec_done), 32'd1);

        // Priority clear > load > step, then load clamp
        do_load(10);
        clr = 1; ld = 1; ld_val = 20; en = 1; step();
        clr = 0; ld = 0;
        check("prio_count", 32'(sec_count), 32'd0);
        check("prio_done", 32'(sec_done), 32'd0);
        do_load(63);
        check("clamp_count", 32'(sec_count), 32'd59);

        // Lap with simultaneous clear
        do_load(25);
        wrap = MODE_WRAP; en = 1; lap = 1; clr = 1; step();
        lap = 0; clr = 0; en = 0;
        check("lap_val", 32'(sec_lap_val), 32'd25);
        check("lap_valid", 32'(sec_lap_valid), 32'd1);
        check("lap_clr_count", 32'(sec_count), 32'd0);
        step();
        check("lap_valid_drop", 32'(sec_lap_valid), 32'd0);
        check("lap_val_hold", 32'(sec_lap_val), 32'd25);

        // Cascade: one full hour of seconds, then pause
        rst = 1; step(); rst = 0;
        en = 1; dir = DIR_UP; wrap = MODE_WRAP; min_max = 0;
        for (int i = 0; i < 3600; i++) begin
            step();
            if (int'(min_count) > min_max) min_max = int'(min_count);
        end
        check("casc_min_max", 32'(min_max), 32'd59);
        check("casc_sec_end", 32'(sec_count), 32'd0);
        check("casc_min_end", 32'(min_count), 32'd0);
        for (int i = 0; i < 75; i++) step();
        en = 0; hold_sec = sec_count; hold_min = min_count;
        for (int i = 0; i < 5; i++) step();
        check("pause_sec", 32'(sec_count), 32'(hold_sec));
        check("pause_min", 32'(min_count), 32'(hold_min));

        // Reset while saturated with a captured lap
        do_load(7);
        lap = 1; step(); lap = 0;
        en = 1; dir = DIR_DOWN; wrap = MODE_SAT;
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_done", 32'(sec_done), 32'd1);
        check("pre_rst_lap", 32'(sec_lap_val), 32'd7);
        rst = 1; step(); rst = 0;
        check("mid_rst_count", 32'(sec_count), 32'd0);
        check("mid_rst_done", 32'(sec_done), 32'd0);
        check("mid_rst_lap_val", 32'(sec_lap_val), 32'd0);
        check("mid_rst_lap_valid", 32'(sec_lap_valid), 32'd0);

        // Randomized mix of all controls
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            en         = ($urandom_range(0, 9) != 0);
            dir        = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            wrap       = ($urandom_range(0, 3) != 0);
            clr        = ($urandom_range(0, 63) == 0);
            ld         = ($urandom_range(0, 39) == 0);
            ld_val     = W'($urandom_range(0, 63));
            lap        = ($urandom_range(0, 5) == 0);
            min_clr    = ($urandom_range(0, 127) == 0);
            min_ld     = ($urandom_range(0, 63) == 0);
            min_ld_val = W'($urandom_range(0, 63));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mod_n_counter

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised, generalised successor of the stopwatch seconds counter. It is a modulo-N up/down counter with these features:
- synchronous clear and load
- wrap or saturate mode
- terminal-count carry/borrow output for cascading stages (sec -> min -> hr)
- a lap-capture register for split times

One instance per time digit group. Stages are chained by feeding one stage's ovf into the next stage's enable.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; must be >= 2
WIDTH, 6, count width; must satisfy 2^WIDTH >= MODULUS
RESET_VAL, 0, count value after reset/clear; must be < MODULUS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
enable  in  1  count-step qualifier; low = pause (hold)
dir  in  1  0 = count up, 1 = count down
wrap_en  in  1  1 = wrap at terminal, 0 = saturate and halt at terminal
clear  in  1  synchronous clear to RESET_VAL
load  in  1  synchronous load of load_val
load_val  in  WIDTH  preset value
lap  in  1  capture current count into lap_val
count  out  WIDTH  registered count value
ovf  out  1  combinational carry/borrow: this stage wraps on the coming edge
done  out  1  registered sticky flag: saturate mode reached terminal
lap_val  out  WIDTH  registered captured count
lap_valid  out  1  registered one-cycle pulse, cycle after capture

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - count = RESET_VAL
  - done = 0
  - lap_val = 0
  - lap_valid = 0
  - ovf = 0 while rst is high
- Terminal value: MODULUS-1 when dir=0; 0 when dir=1. at_term = (count == terminal for the current dir).
- count update priority per edge: rst > clear > load > step > hold.
  - clear: count = RESET_VAL, done = 0.
  - load: count = load_val, or MODULUS-1 if load_val >= MODULUS (clamp); done = 0.
  - step (enable=1, done=0):
    - not at_term: count +1 (up) or -1 (down).
    - at_term, wrap_en=1: up wraps to 0; down wraps to MODULUS-1.
    - at_term, wrap_en=0: count holds; done = 1.
  - done=1: count holds regardless of enable/dir until clear, load or rst.
- ovf = enable & at_term & wrap_en & ~done & ~clear & ~load & ~rst. It is purely combinational, same cycle, with no register latency, so cascaded stages step on the same edge.
- Lap capture:
  - lap=1 at an edge: lap_val = count as it was before that edge's update. This includes simultaneous clear, load or step; the pre-update value is captured.
  - lap_valid = 1 for exactly the following cycle.
  - Back-to-back lap pulses capture every cycle; lap_valid stays high.
  - lap_val holds until the next lap or rst. clear and load do not affect lap_val.
- Mode changes:
  - dir or wrap_en changes take effect at the same edge. No pipeline.
  - Changing dir while done=1 does not release done.
- Out-of-range count (>= MODULUS) is unreachable except by illegal parameters. No recovery logic is required.
- Latency: count is visible 1 cycle after the qualifying edge. ovf has zero cycles of latency.

Decomposition:
- Shared package time_pkg:
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1
  - MODE_SAT = 1'b0, MODE_WRAP = 1'b1
  - SEC_MOD = 60, MIN_MOD = 60, HR_MOD = 24
- No sub-module. Count, done and lap logic are small enough to stay inline. Cascading is done by the parent (stopwatch top), not inside this block.

Test Plan:
1. Up wrap, MODULUS=60: rst, enable=1, dir=0, wrap_en=1 for 61 cycles -> count 0..59,0,1; ovf high only in the cycle count=59.
2. Down saturate: load_val=3, load; then enable=1, dir=1, wrap_en=0 -> count 3,2,1,0,0,...; done=1 from the edge at 0; ovf never high; further enable leaves count=0.
3. Priority: count=10, assert clear, load (load_val=20) and enable together -> count=RESET_VAL, done=0; then load alone with load_val=63 -> count=59 (clamp).
4. Lap: at count=25 with enable=1, pulse lap while also asserting clear -> next cycle lap_val=25, lap_valid=1, count=0; the cycle after, lap_valid=0 and lap_val stays 25.
5. Pause/cascade: two instances (sec MODULUS=60, min MODULUS=60), min.enable = sec.ovf. Run 3600 cycles -> min reaches 59 then 0 together with sec 59->0. Drop enable mid-run -> both hold and ovf=0.
6. Reset mid-operation: rst=1 while done=1, count=0, lap_val=7 -> next cycle count=RESET_VAL, done=0, lap_val=0, lap_valid=0.
